// File: rtl/activation_arbiter.sv
// Round-robin arbiter feeding a shared piecewise-linear sigmoid pipeline (S1 operand, S2 sigmoid).
// Define ACT_ARB_DERIV_EN to add req_deriv and stage S3 computing s*(1-s) per request.
module activation_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
`ifdef ACT_ARB_DERIV_EN
  input  logic [NUM_REQ-1:0]      req_deriv,
`endif
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  input  logic                    rsp_ready,
  output logic [15:0]             done_cnt
);
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ONE = 32'h0001_0000;

  function automatic logic [DATA_W-1:0] sigmoid(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] a, f, r;
    a = x[DATA_W-1] ? unsigned'(-x) : unsigned'(x);
    if (a >= 32'h0005_0000)      f = ONE;
    else if (a >= 32'h0002_6000) f = (a >> 5) + 32'h0000_D800;
    else if (a >= ONE)           f = (a >> 3) + 32'h0000_A000;
    else                         f = (a >> 2) + 32'h0000_8000;
    r = x[DATA_W-1] ? (ONE - f) : f;
    // A zero probability is never emitted; clamp to the smallest positive code.
    if (r == '0) r = 32'h0000_0001;
    return r;
  endfunction

  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_id;
  logic                     gnt_any, avail_p1, adv_p2, rsp_fire;
  logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic signed [DATA_W-1:0] data_p1_q, data_p1_d;
  logic [DATA_W-1:0]        data_p2_q, data_p2_d;
  logic [ID_W-1:0]          id_p1_q, id_p1_d, id_p2_q, id_p2_d;
  logic [15:0]              done_q, done_d;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    if (rst_n && avail_p1) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_any && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
          gnt_id  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
          gnt_any = 1'b1;
        end
      end
    end
    if (gnt_any) gnt = NUM_REQ'(1) << gnt_id;
    ptr_d = gnt_any ? ID_W'((int'(gnt_id) + 1) % NUM_REQ) : ptr_q;
  end

  assign req_ready = gnt;
  assign avail_p1  = !vld_p1_q || adv_p2;

  // Stage 1: granted operand capture
  always_comb begin
    vld_p1_d  = gnt_any | (vld_p1_q & ~adv_p2);
    data_p1_d = gnt_any ? $signed(req_data[int'(gnt_id)*DATA_W +: DATA_W]) : data_p1_q;
    id_p1_d   = gnt_any ? gnt_id : id_p1_q;
  end

  // Stage 2: sigmoid evaluation
  always_comb begin
    vld_p2_d  = adv_p2 ? vld_p1_q : vld_p2_q;
    data_p2_d = (adv_p2 && vld_p1_q) ? sigmoid(data_p1_q) : data_p2_q;
    id_p2_d   = (adv_p2 && vld_p1_q) ? id_p1_q : id_p2_q;
  end

  assign rsp_fire = rsp_valid && rsp_ready;
  assign done_d   = (rsp_fire && done_q != 16'hFFFF) ? done_q + 16'd1 : done_q;
  assign done_cnt = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      done_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    data_p1_q <= data_p1_d;
    id_p1_q   <= id_p1_d;
  end

`ifdef ACT_ARB_DERIV_EN
  function automatic logic [DATA_W-1:0] deriv(input logic [DATA_W-1:0] s);
    logic [2*DATA_W-1:0] p;
    p = {32'b0, s} * {32'b0, ONE - s};
    return p[DATA_W+15:16];
  endfunction

  logic              adv_p3, drv_p1_q, drv_p1_d, drv_p2_q, drv_p2_d;
  logic              vld_p3_q, vld_p3_d;
  logic [DATA_W-1:0] data_p3_q, data_p3_d;
  logic [ID_W-1:0]   id_p3_q, id_p3_d;

  assign adv_p3 = !vld_p3_q || rsp_ready;
  assign adv_p2 = !vld_p2_q || adv_p3;

  // Stage 3: optional derivative
  always_comb begin
    drv_p1_d  = gnt_any ? req_deriv[gnt_id] : drv_p1_q;
    drv_p2_d  = (adv_p2 && vld_p1_q) ? drv_p1_q : drv_p2_q;
    vld_p3_d  = adv_p3 ? vld_p2_q : vld_p3_q;
    data_p3_d = (adv_p3 && vld_p2_q) ? (drv_p2_q ? deriv(data_p2_q) : data_p2_q) : data_p3_q;
    id_p3_d   = (adv_p3 && vld_p2_q) ? id_p2_q : id_p3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p3_q  <= 1'b0;
      data_p3_q <= '0;
      id_p3_q   <= '0;
    end else begin
      vld_p3_q  <= vld_p3_d;
      data_p3_q <= data_p3_d;
      id_p3_q   <= id_p3_d;
    end
  end

  always_ff @(posedge clk) begin
    drv_p1_q  <= drv_p1_d;
    drv_p2_q  <= drv_p2_d;
    data_p2_q <= data_p2_d;
    id_p2_q   <= id_p2_d;
  end

  assign rsp_valid = vld_p3_q;
  assign rsp_data  = data_p3_q;
  assign rsp_id    = id_p3_q;
`else
  assign adv_p2 = !vld_p2_q || rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p2_q <= '0;
      id_p2_q   <= '0;
    end else begin
      data_p2_q <= data_p2_d;
      id_p2_q   <= id_p2_d;
    end
  end

  assign rsp_valid = vld_p2_q;
  assign rsp_data  = data_p2_q;
  assign rsp_id    = id_p2_q;
`endif
endmodule

// File: tb/tb_activation_arbiter.sv
// Randomized and directed bench for activation_arbiter against an in-flight queue model.
module tb_activation_arbiter;
  localparam int N = 4;
`ifdef ACT_ARB_DERIV_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_deriv;
  logic [32*N-1:0] req_data;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic [15:0]     done_cnt;

  activation_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
`ifdef ACT_ARB_DERIV_EN
    .req_deriv(req_deriv),
`endif
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] x; bit dv; int cyc; } item_t;
  item_t q[$];
  int m_ptr = 0, m_done = 0, cyc = 0;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Sigmoid from the breakpoint table, in plain integer arithmetic (units of 1/65536).
  function automatic logic [31:0] ref_out(input logic [31:0] x, input bit dv);
    longint xs, a, f, r;
    xs = longint'($signed(x));
    a  = (xs < 0) ? -xs : xs;
    if (a >= 5 * 65536)           f = 65536;
    else if (a * 8 >= 19 * 65536) f = a / 32 + 55296;
    else if (a >= 65536)          f = a / 8 + 40960;
    else                          f = a / 4 + 32768;
    r = (xs < 0) ? 65536 - f : f;
    if (r == 0) r = 1;
`ifdef ACT_ARB_DERIV_EN
    if (dv) r = (r * (65536 - r)) / 65536;
`endif
    return r[31:0];
  endfunction

  function automatic logic [31:0] rnd_x();
    logic [31:0] sp [6];
    sp = '{32'h0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFA_0000, 32'h0050_0000, 32'hFFFD_A000};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 12 * 65536)) - 32'd393216;
      2:       return sp[$urandom_range(0, 5)];
      default: return 32'($urandom_range(0, 65535)) - 32'd32768;
    endcase
  endfunction

  function automatic logic [32*N-1:0] rnd_bus();
    logic [32*N-1:0] d;
    for (int i = 0; i < N; i++) d[i*32 +: 32] = rnd_x();
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr  = 0;
    m_done = 0;
  endtask

  // One cycle: drive at negedge, check, advance model, wait for the next negedge.
  task automatic step(input logic [N-1:0] v, input logic [32*N-1:0] d, input logic r,
                      input logic [N-1:0] dv, output int g);
    logic [N-1:0] eg;
    bit ev;
    item_t it;
    req_valid = v; req_data = d; rsp_ready = r; req_deriv = dv;
    #1;
    g  = -1;
    eg = '0;
    if (q.size() < LAT || r) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(eg));
    ev = (q.size() > 0) && (cyc >= q[0].cyc + LAT);
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_data", rsp_data, ref_out(q[0].x, q[0].dv));
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
    end
    chk("done_cnt", 32'(done_cnt), 32'(m_done));
    if (ev && r) begin
      void'(q.pop_front());
      if (m_done < 65535) m_done++;
    end
    if (g >= 0) begin
      it.id = g; it.x = d[g*32 +: 32]; it.dv = dv[g]; it.cyc = cyc;
      q.push_back(it);
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic single(input logic [31:0] x, input bit dv, input logic [31:0] lit, input string tag);
    int g;
    step(4'b0001, {96'b0, x}, 1'b1, {3'b0, dv}, g);
    repeat (LAT - 1) step('0, '0, 1'b1, '0, g);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk(tag, rsp_data, lit);
    chk({tag, "_id"}, 32'(rsp_id), 32'd0);
    step('0, '0, 1'b1, '0, g);
  endtask

  task automatic drain();
    int g;
    repeat (LAT + 2) step('0, '0, 1'b1, '0, g);
  endtask

  initial begin
    int g, acc, base;
    logic [N-1:0] rv;
    rst_n = 1'b0; req_valid = '1; req_data = '0; rsp_ready = 1'b1; req_deriv = '0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    single(32'h0001_0000, 1'b0, 32'h0000_C000, "sig_one");
    single(32'h0000_0000, 1'b0, 32'h0000_8000, "sig_zero");
    single(32'hFFFF_0000, 1'b0, 32'h0000_4000, "sig_neg1");
    single(32'hFFFA_0000, 1'b0, 32'h0000_0001, "sig_floor");
    single(32'h0050_0000, 1'b0, 32'h0001_0000, "sig_sat");
`ifdef ACT_ARB_DERIV_EN
    single(32'h0000_0000, 1'b1, 32'h0000_4000, "deriv_zero");
`endif

    // Fairness from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid = '1; rsp_ready = 1'b1;
      #1;
      chk("fair_gnt", 32'(req_ready), 32'(1) << (i % 4));
      if (i >= LAT) chk("fair_id", 32'(rsp_id), 32'((i - LAT) % 4));
      step('1, rnd_bus(), 1'b1, '0, g);
    end
    drain();

    // Backpressure
    base = m_done;
    acc  = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001; rsp_ready = 1'b0;
      #1;
      if (i >= LAT) chk("bp_stall", 32'(req_ready), 32'd0);
      step(4'b0001, rnd_bus(), 1'b0, '0, g);
      if (g >= 0) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'(LAT));
    for (int i = 0; i < 20 && acc < 6; i++) begin
      step(4'b0001, rnd_bus(), 1'b1, '0, g);
      if (g >= 0) acc++;
    end
    chk("bp_total", 32'(acc), 32'd6);
    drain();
    chk("bp_done", 32'(done_cnt), 32'(base + 6));

    // Reset with the pipeline full
    repeat (LAT) step('1, rnd_bus(), 1'b0, '0, g);
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '1; rsp_ready = 1'b1;
    #1;
    chk("mid_rst_ptr", 32'(req_ready), 32'd1);
    step('1, rnd_bus(), 1'b1, '0, g);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rv = N'($urandom);
      step(rv, rnd_bus(), ($urandom_range(0, 9) < 7), N'($urandom), g);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/activation_arbiter.md
ACTIVATION_ARBITER -- requirements
Module: activation_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the sigmoid unit (2..8).
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), width of the requester index.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 req_data  input  32*NUM_REQ  Q16.16 two's-complement operands; requester i uses bits [32i+31:32i].
REQ-007 req_ready  output  NUM_REQ  per-requester accept (grant) strobe.
REQ-008 rsp_valid  output  1  result valid.
REQ-009 rsp_data  output  32  Q16.16 result.
REQ-010 rsp_id  output  ID_W  index of the requester that owns rsp_data.
REQ-011 rsp_ready  input  1  downstream accepts the result.
REQ-012 done_cnt  output  16  count of completed responses, saturating at 0xFFFF.

Function
REQ-013 A transfer occurs on requester i when req_valid[i] and req_ready[i] are both high at a rising clk edge; a response transfer occurs when rsp_valid and rsp_ready are both high.
REQ-014 req_ready SHALL be one-hot or zero, combinational from req_valid, the priority pointer and stage-1 availability; it SHALL never depend on req_data.
REQ-015 Arbitration SHALL be round-robin: search starts at the pointer and wraps modulo NUM_REQ; the first valid requester is granted.
REQ-016 After a grant to i, the pointer SHALL become (i+1) mod NUM_REQ; it SHALL hold when there is no grant.
REQ-017 Stage 1 (S1) SHALL register the granted operand and its id; S1 is available when empty or when its contents move to S2 in the same cycle.
REQ-018 Stage 2 (S2) SHALL register the sigmoid of the S1 operand and the S1 id; S2 advances when empty or when rsp_ready is high.
REQ-019 rsp_valid, rsp_data and rsp_id SHALL come directly from S2 and SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-020 Latency SHALL be 2 cycles from request transfer to rsp_valid with rsp_ready held high; throughput SHALL be 1 result per cycle with no bubbles.
REQ-021 Sigmoid on x (Q16.16): compute a=|x|. If a>=5.0, f=1.0. Else if a>=2.375, f=(a>>5)+0.84375. Else if a>=1.0, f=(a>>3)+0.625. Else f=(a>>2)+0.5. Comparisons are unsigned. Shifts truncate.
REQ-022 For x negative, the result SHALL be 1.0-f; for x non-negative, it SHALL be f. A zero result SHALL be replaced by 0x00000001.
REQ-023 done_cnt SHALL increment by 1 on each response transfer and SHALL stick at 0xFFFF.
REQ-024 When S1 and S2 are full and rsp_ready=0, all req_ready SHALL be 0 and the pointer SHALL hold.
REQ-025 Responses SHALL leave in grant order; no operand is dropped or duplicated.

Reset
REQ-026 While rst_n=0: S1/S2 empty, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, pointer=0, done_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operands without emitting a response; the first grant after release SHALL search from index 0.

Configuration
REQ-028 Macro ACT_ARB_DERIV_EN: when defined, add input req_deriv (NUM_REQ bits, sampled with the request transfer) and a stage S3.
REQ-029 With ACT_ARB_DERIV_EN defined, S3 SHALL output s*(1.0-s) when the request's req_deriv bit was 1, and s otherwise.
REQ-030 With ACT_ARB_DERIV_EN defined, the product SHALL be the 64-bit product >>16, truncated to 32 bits; latency SHALL be 3 cycles for all requests and the response interface SHALL come from S3.
REQ-031 Without ACT_ARB_DERIV_EN, the req_deriv port and S3 SHALL be absent and the latency SHALL be 2 cycles.

Verification
REQ-032 Single request, rsp_ready=1: req 0 data 0x00010000 -> rsp_data 0x0000C000, rsp_id 0, exactly 2 cycles later; 0x00000000 -> 0x00008000.
REQ-033 Negative and saturation: 0xFFFF0000 -> 0x00004000; 0xFFFA0000 -> 0x00000001; 0x00500000 -> 0x00010000.
REQ-034 Fairness: all 4 req_valid high for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, and rsp_id follows the same order.
REQ-035 Backpressure: stream of 6 requests with rsp_ready low for 5 cycles -> req_ready goes to 0 after 2 accepts, rsp_data is stable, and all 6 results arrive in order with done_cnt=6.
REQ-036 Reset mid-stream: rst_n low with S1/S2 full -> rsp_valid=0 immediately, no stale response after release, and the pointer restarts at 0.
REQ-037 ACT_ARB_DERIV_EN build: req_deriv=1 with data 0x00000000 -> rsp_data 0x00004000 after 3 cycles; req_deriv=0 with the same data -> 0x00008000.
